// File: rtl/lh_ptxt_sender.sv
// Host-side framer for the light-hash core: buffers alphanumeric chars, sends 0xFF/payload/0x00
// as spaced strobes, then waits for the digest. Optional compare logic under LH_SEND_COMPARE_EN.
module lh_ptxt_sender #(
  parameter int DEPTH    = 16,
  parameter int CHAR_GAP = 34,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  wr_char,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        err_invalid_char,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [63:0] digest_out,
  output logic [7:0]  ptxt_char,
  output logic        ptxt_valid,
  input  logic [63:0] digest,
  input  logic        digest_ready
`ifdef LH_SEND_COMPARE_EN
  ,
  input  logic [63:0] expected_digest,
  output logic        match
`endif
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_MAX = (CHAR_GAP > TIMEOUT) ? CHAR_GAP : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(CHAR_GAP - 1);
  localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);
  localparam logic [PTR_W:0]   FULL   = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   FILL_1 = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_1  = PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_START, S_SEND_CHAR, S_SEND_FINISH, S_WAIT_DIGEST, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W:0]   fill_q, fill_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]       ptxt_char_q, ptxt_char_d;
  logic             ptxt_valid_q, ptxt_valid_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;
  logic [63:0]      digest_out_q, digest_out_d;
  logic [7:0]       mem_q [DEPTH];
  logic             char_ok, push, pop;
`ifdef LH_SEND_COMPARE_EN
  logic [63:0]      exp_q, exp_d;
  logic             match_q, match_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q != '0) ? cnt_q - CNT_1 : cnt_q;
    fill_d       = fill_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ptxt_char_d  = ptxt_char_q;
    ptxt_valid_d = 1'b0;
    timeout_d    = timeout_q;
    digest_out_d = digest_out_q;
    pop          = 1'b0;
`ifdef LH_SEND_COMPARE_EN
    exp_d        = exp_q;
    match_d      = match_q;
`endif
    char_ok  = (wr_char >= 8'h30 && wr_char <= 8'h39) ||
               (wr_char >= 8'h41 && wr_char <= 8'h5A) ||
               (wr_char >= 8'h61 && wr_char <= 8'h7A);
    wr_ready = (state_q == S_IDLE) && (fill_q != FULL);
    push     = wr_valid && wr_ready && char_ok;
    err_d    = wr_valid && wr_ready && !char_ok;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SEND_START;
          ptxt_char_d  = 8'hFF;
          ptxt_valid_d = 1'b1;
          cnt_d        = GAP_LD;
          timeout_d    = 1'b0;
`ifdef LH_SEND_COMPARE_EN
          exp_d        = expected_digest;
          match_d      = 1'b0;
`endif
        end
      end
      S_SEND_START, S_SEND_CHAR: begin
        // Next strobe fires on the last gap cycle so it is visible exactly CHAR_GAP after the previous one.
        if (cnt_q == '0) begin
          cnt_d        = GAP_LD;
          ptxt_valid_d = 1'b1;
          if (fill_q != '0) begin
            pop         = 1'b1;
            ptxt_char_d = mem_q[rd_ptr_q];
            state_d     = S_SEND_CHAR;
          end else begin
            ptxt_char_d = 8'h00;
            state_d     = S_SEND_FINISH;
          end
        end
      end
      S_SEND_FINISH: begin
        if (cnt_q == '0) begin
          cnt_d   = TMO_LD;
          state_d = S_WAIT_DIGEST;
        end
      end
      S_WAIT_DIGEST: begin
        if (digest_ready) begin
          digest_out_d = digest;
          state_d      = S_DONE;
`ifdef LH_SEND_COMPARE_EN
          match_d      = (digest == exp_q);
`endif
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
`ifdef LH_SEND_COMPARE_EN
          match_d   = 1'b0;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      fill_d   = fill_q + FILL_1;
      wr_ptr_d = wr_ptr_q + PTR_1;
    end
    if (pop) begin
      fill_d   = fill_q - FILL_1;
      rd_ptr_d = rd_ptr_q + PTR_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fill_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ptxt_char_q  <= 8'h00;
      ptxt_valid_q <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
      digest_out_q <= '0;
`ifdef LH_SEND_COMPARE_EN
      exp_q        <= '0;
      match_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_q       <= fill_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ptxt_char_q  <= ptxt_char_d;
      ptxt_valid_q <= ptxt_valid_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
      digest_out_q <= digest_out_d;
`ifdef LH_SEND_COMPARE_EN
      exp_q        <= exp_d;
      match_q      <= match_d;
`endif
    end
  end

  // Storage needs no reset: the pointers and fill define what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_char;
  end

  assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done             = (state_q == S_DONE);
  assign timeout          = timeout_q;
  assign digest_out       = digest_out_q;
  assign ptxt_char        = ptxt_char_q;
  assign ptxt_valid       = ptxt_valid_q;
  assign err_invalid_char = err_q;
`ifdef LH_SEND_COMPARE_EN
  assign match            = match_q;
`endif

endmodule

// File: tb/tb_lh_ptxt_sender.sv
// Scoreboard bench for lh_ptxt_sender: a message-level model predicts strobes, errors and done
// records into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_lh_ptxt_sender;
  localparam int DEPTH = 16;
  localparam int GAP   = 34;
  localparam int TMO   = 255;
  localparam int NEVER = 32'h3FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  wr_char = 8'h00;
  logic        wr_valid = 1'b0;
  logic        wr_ready, err_invalid_char;
  logic        start = 1'b0;
  logic        busy, done, timeout;
  logic [63:0] digest_out;
  logic [7:0]  ptxt_char;
  logic        ptxt_valid;
  logic [63:0] digest = '0;
  logic        digest_ready = 1'b0;
`ifdef LH_SEND_COMPARE_EN
  logic [63:0] expected_digest = '0;
  logic        match;
`endif

  lh_ptxt_sender #(.DEPTH(DEPTH), .CHAR_GAP(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_char(wr_char), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .err_invalid_char(err_invalid_char), .start(start), .busy(busy), .done(done),
    .timeout(timeout), .digest_out(digest_out), .ptxt_char(ptxt_char), .ptxt_valid(ptxt_valid),
    .digest(digest), .digest_ready(digest_ready)
`ifdef LH_SEND_COMPARE_EN
    , .expected_digest(expected_digest), .match(match)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] ch; int cy; } strobe_t;
  typedef struct { int cy; logic [63:0] dig; logic tmo; logic mat; } done_t;

  strobe_t     exp_strb[$];
  done_t       exp_done[$];
  int          exp_err[$];
  logic [7:0]  msg[$];
  logic [63:0] model_dig = '0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          p_delay;
  logic [63:0] p_dig, p_exp;
  int          resp_cycle, end_cycle;
  strobe_t     m_s;
  done_t       m_d;
  int          m_e;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ptxt_valid) begin
        if (exp_strb.size() == 0) fail_now("unexpected_strobe");
        else begin
          m_s = exp_strb.pop_front();
          check("strobe_char", ptxt_char, m_s.ch);
          check("strobe_cycle", cyc, m_s.cy);
        end
      end
      if (err_invalid_char) begin
        if (exp_err.size() == 0) fail_now("unexpected_err_pulse");
        else begin
          m_e = exp_err.pop_front();
          check("err_cycle", cyc, m_e);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) fail_now("unexpected_done");
        else begin
          m_d = exp_done.pop_front();
          check("done_cycle", cyc, m_d.cy);
          check("digest_out", digest_out, m_d.dig);
          check("timeout_flag", timeout, m_d.tmo);
`ifdef LH_SEND_COMPARE_EN
          check("match", match, m_d.mat);
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_valid();
    int r = $urandom_range(0, 61);
    if (r < 10) return 8'(8'h30 + r);
    if (r < 36) return 8'(8'h41 + r - 10);
    return 8'(8'h61 + r - 36);
  endfunction

  function automatic bit is_alnum(logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
  endfunction

  task automatic set_resp(int d, logic [63:0] dig, logic [63:0] expv);
    p_delay = d;
    p_dig   = dig;
    p_exp   = expv;
  endtask

  // Frame timing from the message: FF at c0+1, char k at c0+1+(k+1)*GAP, 00 after the last char.
  task automatic plan(int c0);
    int n = msg.size();
    int f = c0 + 1 + (n + 1) * GAP;
    int w = f + GAP;
    int lat;
    strobe_t s;
    done_t d;
    s.ch = 8'hFF; s.cy = c0 + 1; exp_strb.push_back(s);
    for (int k = 0; k < n; k++) begin
      s.ch = msg[k]; s.cy = c0 + 1 + (k + 1) * GAP; exp_strb.push_back(s);
    end
    s.ch = 8'h00; s.cy = f; exp_strb.push_back(s);
    msg.delete();
    resp_cycle = (p_delay < 0) ? NEVER : f + p_delay;
    lat = (resp_cycle > w) ? resp_cycle : w;
    if (p_delay >= 0 && lat <= w + TMO - 1) begin
      d.cy = lat + 1; model_dig = p_dig; d.tmo = 1'b0; d.mat = (p_dig == p_exp);
    end else begin
      d.cy = w + TMO; d.tmo = 1'b1; d.mat = 1'b0;
    end
    d.dig = model_dig;
    exp_done.push_back(d);
    end_cycle = d.cy + 2;
`ifdef LH_SEND_COMPARE_EN
    expected_digest = p_exp;
`endif
  endtask

  task automatic do_write(logic [7:0] c, bit st);
    check("wr_ready", wr_ready, msg.size() < DEPTH);
    wr_char  = c;
    wr_valid = 1'b1;
    start    = st;
    if (msg.size() < DEPTH) begin
      if (is_alnum(c)) msg.push_back(c);
      else exp_err.push_back(cyc + 1);
    end
    if (st) plan(cyc);
    tick();
    wr_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_wait();
    check("busy_after_start", busy, 1);
    check("timeout_cleared", timeout, 0);
    while (cyc < end_cycle) begin
      digest_ready = (cyc >= resp_cycle);
      digest       = p_dig;
      tick();
    end
    digest_ready = 1'b0;
    check("idle_after_done", busy, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    plan(cyc);
    tick();
    start = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rc;
    bit with_ch;
    logic [7:0] c;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ptxt_valid", ptxt_valid, 0);
    check("rst_ptxt_char", ptxt_char, 0);
    check("rst_digest_out", digest_out, 0);
    check("rst_timeout", timeout, 0);
    check("rst_err", err_invalid_char, 0);
    rst_n = 1'b1;
    tick();

    // "Ab9" with the responder holding ready from 5 cycles after the finish byte.
    set_resp(5, 64'h0123_4567_89AB_CDEF, 64'h0);
    do_write(8'h41, 0); do_write(8'h62, 0); do_write(8'h39, 0);
    do_start(); run_wait();

    // Invalid chars only, then an empty message.
    do_write(8'h2A, 0); do_write(8'h00, 0); do_write(8'hFF, 0);
    tick();
    set_resp(3, 64'h1111_2222_3333_4444, 64'h0);
    do_start(); run_wait();

    // Full buffer, 17th write dropped silently, start coincides with it.
    for (int i = 0; i < DEPTH; i++) do_write(rand_valid(), 0);
    set_resp(0, 64'hA5A5_0000_FFFF_5A5A, 64'h0);
    do_write(8'h2A, 1); run_wait();

    // No digest: timeout keeps the previous digest.
    do_write(8'h5A, 0);
    set_resp(-1, 64'h0, 64'h0);
    do_start(); run_wait();

    // Stray digest_ready while idle is ignored.
    digest = 64'hBAD0_BAD0_BAD0_BAD0;
    digest_ready = 1'b1;
    repeat (3) tick();
    digest_ready = 1'b0;
    check("stray_digest_ignored", digest_out, model_dig);

    // Ready arriving on the last allowed cycle, then one cycle too late.
    do_write(8'h7A, 0);
    set_resp(GAP + TMO - 1, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0);
    do_start(); run_wait();
    set_resp(GAP + TMO, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0);
    do_start(); run_wait();

`ifdef LH_SEND_COMPARE_EN
    do_write(8'h31, 0);
    set_resp(2, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001);
    do_start(); run_wait();
    do_write(8'h32, 0);
    set_resp(2, 64'hDEAD_BEEF_0002_0001, 64'hDEAD_BEEF_0000_0001);
    do_start(); run_wait();
`endif

    // Reset in SEND_CHAR, on the strobe cycle of the second char.
    do_write(8'h48, 0); do_write(8'h45, 0); do_write(8'h4C, 0);
    set_resp(5, 64'h1234, 64'h0);
    do_start();
    rc = cyc + 2 * GAP;
    while (cyc < rc) tick();
    rst_n = 1'b0;
    #1;
    check("rstmid_ptxt_valid", ptxt_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_wr_ready", wr_ready, 1);
    check("rstmid_done", done, 0);
    exp_strb.delete(); exp_done.delete(); msg.delete();
    model_dig = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rstmid_digest_out", digest_out, 0);

    // Randomized transfers.
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(0, DEPTH + 2);
      with_ch = (n > 0) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n - (with_ch ? 1 : 0); i++) begin
        c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : rand_valid();
        do_write(c, 0);
      end
      case ($urandom_range(0, 5))
        0:       p_delay = -1;
        1:       p_delay = GAP + TMO - 1;
        2:       p_delay = GAP + TMO;
        default: p_delay = $urandom_range(0, 60);
      endcase
      p_dig = {$urandom, $urandom};
      p_exp = ($urandom_range(0, 1) == 1) ? p_dig : {$urandom, $urandom};
      if (with_ch) do_write(rand_valid(), 1);
      else do_start();
      run_wait();
    end

    check("strobes_pending", exp_strb.size(), 0);
    check("done_pending", exp_done.size(), 0);
    check("err_pending", exp_err.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lh_ptxt_sender.md
Name: lh_ptxt_sender

Overview:
Host-side transmitter for the light-hash core. Buffers an alphanumeric message written by a host and frames it as start byte 0xFF, payload characters, then finish byte 0x00. Each byte is sent as a one-cycle ptxt_valid strobe, spaced so the core can finish its per-byte iterations. After the finish byte it waits for digest_ready and latches the 64-bit digest for the host.

Parameters:
DEPTH, 16, message buffer depth in characters (power of 2, ≥2)
CHAR_GAP, 34, cycles from one ptxt_valid strobe to the next (≥2)
TIMEOUT, 255, max cycles in WAIT_DIGEST before abort (≥1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
wr_char  input  8  host message character
wr_valid  input  1  host write strobe
wr_ready  output  1  buffer accepts a write this cycle
err_invalid_char  output  1  1-cycle pulse: written char rejected
start  input  1  begin sending the buffered message
busy  output  1  transfer in progress
done  output  1  1-cycle pulse: transfer finished
timeout  output  1  sticky: last transfer hit TIMEOUT; cleared on next accepted start
digest_out  output  64  latched digest
ptxt_char  output  8  byte to hash core
ptxt_valid  output  1  1-cycle byte strobe to hash core
digest  input  64  digest from hash core
digest_ready  input  1  digest valid from hash core

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. All outputs are 0 on reset (ptxt_char=0x00, digest_out=0). Buffer is emptied and the FSM goes to IDLE. Assertion mid-transfer aborts immediately, with no done pulse.
- wr_ready = (state==IDLE) && (fill<DEPTH).
- Write acceptance: a write is accepted when wr_valid && wr_ready and the char is in 0x30–0x39, 0x41–0x5A or 0x61–0x7A.
- Rejected writes: any other char with wr_valid && wr_ready is dropped, err_invalid_char pulses next cycle, fill is unchanged.
- wr_valid while !wr_ready is ignored silently.
- FSM states: IDLE, SEND_START, SEND_CHAR, SEND_FINISH, WAIT_DIGEST, DONE.
- IDLE: start=1 moves to SEND_START and sets busy next cycle. A valid write in the same cycle as start is accepted and included in the message. start outside IDLE is ignored.
- SEND_* strobe: on entry, drive ptxt_char and pulse ptxt_valid for exactly 1 cycle. Then hold ptxt_char with ptxt_valid=0 for CHAR_GAP-1 cycles before the next strobe.
- SEND_START sends 0xFF, then goes to SEND_CHAR if fill>0, else SEND_FINISH. An empty message is legal.
- SEND_CHAR pops chars in FIFO order, one per strobe, until the buffer is empty, then goes to SEND_FINISH.
- SEND_FINISH sends 0x00. After its gap, go to WAIT_DIGEST.
- WAIT_DIGEST: the first cycle with digest_ready=1 latches digest into digest_out and goes to DONE.
- Timeout: after TIMEOUT cycles with no digest_ready, set timeout=1, leave digest_out unchanged and go to DONE.
- Stray digest_ready: while not in WAIT_DIGEST it is ignored.
- DONE: pulse done for 1 cycle, clear busy, return to IDLE. The buffer is now empty.
- Timing: with start sampled at cycle 0 and N chars, 0xFF strobes at cycle 1, char k (0-based) at 1+(k+1)·CHAR_GAP, and 0x00 at 1+(N+1)·CHAR_GAP.
- Fill counter: log2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.

Optional Feature:
LH_SEND_COMPARE_EN
- Defined: adds input expected_digest[63:0], sampled on the accepted start cycle, and output match (1 bit).
- match is valid with done: 1 iff a digest was latched and it equals the sampled expected value; forced 0 on timeout.
- match resets to 0 and clears on the next accepted start.
- Undefined: neither port exists and there is no compare logic.

Test Plan:
- Write "Ab9" (0x41,0x62,0x39), start; responder raises digest_ready with 0x0123456789ABCDEF 5 cycles after 0x00 → strobes 0xFF@1, 0x41@35, 0x62@69, 0x39@103, 0x00@137; done pulses; digest_out=0x0123456789ABCDEF.
- Write 0x2A, 0x00, 0xFF → err_invalid_char pulses 3 times, fill stays 0. Start → only 0xFF@1 and 0x00@35 are sent.
- Write 16 chars → wr_ready=0; 17th write dropped without an error pulse. All 16 are sent in order, and wr_ready returns after done.
- Responder never asserts digest_ready → done 255 cycles after WAIT_DIGEST entry, timeout=1, digest_out keeps its previous value. Next start clears timeout.
- Assert rst_n=0 during SEND_CHAR → ptxt_valid=0, busy=0, wr_ready=1, fill=0, and no done pulse.
- With LH_SEND_COMPARE_EN: expected=0xDEADBEEF00000001, responder returns the same value → match=1 with done; a one-bit-different digest → match=0.
